mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-port data memory between two bus masters: m0 (mips core data port) and m1 (DMA/device engine).
//  Sequences each access through a fixed wait-state window and returns a one-cycle ack to the winning master.
//  Sits between the master ports and the memory; the mips be/wen/addr/dout/din port maps onto m0.
// PARAMETERS
//  MEM_LAT     2   access cycles driven to memory per transfer; legal 1..15
//  STARVE_MAX  3   consecutive tie losses tolerated by m1 before forced grant (used only with ARB_CPU_PRIO_EN)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous reset, active-high
//  m0_req     in   1   m0 access request; held with m0_* fields until m0_ack
//  m0_wen     in   1   m0 write (1) / read (0)
//  m0_be      in   4   m0 byte enables
//  m0_addr    in   30  m0 word address [31:2]
//  m0_wdata   in   32  m0 write data
//  m0_rdata   out  32  m0 read data, valid when m0_ack=1
//  m0_ack     out  1   m0 transfer complete, one-cycle pulse
//  m1_req, m1_wen, m1_be, m1_addr, m1_wdata, m1_rdata, m1_ack: same as m0_*, for m1
//  mem_addr   out  30  memory word address
//  mem_be     out  4   memory byte enables
//  mem_wen    out  1   memory write strobe
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data, valid in last ACCESS cycle
//  grant      out  2   one-hot owner (bit0=m0, bit1=m1), 0 when IDLE
//  busy       out  1   1 in ACCESS or RESP
// BEHAVIOUR
//  Reset: state=IDLE; grant, busy, mem_wen, mem_be, m*_ack = 0; mem_addr, mem_wdata, m*_rdata = 0; last_grant=m1 (m0 wins first tie); starve_cnt=0.
//  FSM states: IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE: samples requests. No request: stay. One request: grant it. Both: arbitration rule below. Latch winner's wen, be, addr, wdata; set grant; wait_cnt=MEM_LAT-1; go to ACCESS.
//  ACCESS: mem_addr, mem_be, mem_wdata driven from the latched fields for MEM_LAT cycles. mem_wen=1 only in the final ACCESS cycle of a write; mem_be=0 outside ACCESS.
//    Read: capture mem_rdata on the clock edge that ends the final ACCESS cycle. wait_cnt decrements; at 0 go to RESP.
//  RESP: winner's ack=1 for exactly one cycle; its rdata holds the captured word (write: rdata holds its previous value). Update last_grant. Go to IDLE.
//    Requests are not sampled in RESP. A master holding req one cycle after ack is re-arbitrated as a new request in IDLE.
//  Latency: req seen in IDLE cycle N; ACCESS cycles N+1..N+MEM_LAT; ack at N+MEM_LAT+1. Next grant at N+MEM_LAT+2 at the earliest.
//  Master fields may change while the master is not granted. Once granted, field changes are ignored (latched copy used).
//  Default tie rule (round-robin): winner is the master not in last_grant.
//  A master dropping req while granted does not abort the transfer; the ack is still issued.
//  Reset mid-ACCESS or mid-RESP: immediate return to reset values; no ack; any pending write strobe is suppressed.
//  MEM_LAT outside 1..15: simulation $error at time 0.
// CONFIGURATION
//  ARB_CPU_PRIO_EN defined: m0 wins every tie. starve_cnt counts consecutive ties lost by m1 and saturates at STARVE_MAX.
//    When starve_cnt==STARVE_MAX, m1 wins the next tie and starve_cnt clears. Any m1 grant clears starve_cnt.
//  ARB_CPU_PRIO_EN undefined: strict round-robin as above; starve_cnt logic is absent.
// TESTING
//  1 m0 read, MEM_LAT=2, m0_addr=30'h40 at cycle 0: mem_addr=30'h40 in cycles 1-2; mem_rdata=32'hDEADBEEF; m0_ack=1 and m0_rdata=32'hDEADBEEF in cycle 3.
//  2 m1 write, m1_be=4'b0011, m1_wdata=32'h1234_5678: mem_wen=1 only in cycle 2 with mem_be=4'b0011; m1_ack in cycle 3; m0_ack stays 0.
//  3 m0 and m1 request together from reset, both held, default build: grants in order m0, m1, m0, m1; acks at cycles 3, 7, 11, 15.
//  4 rst pulsed in cycle 1 of an m0 write: mem_wen never asserts; grant=0, busy=0, no ack; a fresh request after reset completes normally.
//  5 ARB_CPU_PRIO_EN, STARVE_MAX=3, both requesting continuously: grant order m0, m0, m0, m1, m0, m0, m0, m1.
//  6 m0 drops req in cycle 1 of its read: transfer still completes; m0_ack in cycle 3; state IDLE in cycle 4.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single-port data memory with a fixed MEM_LAT wait-state window.
// Define ARB_CPU_PRIO_EN for m0 tie priority with bounded m1 starvation; default is round-robin.
module mem_bus_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [3:0]  m0_be,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [3:0]  m1_be,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_bus_arbiter: MEM_LAT=%0d outside legal range 1..15", MEM_LAT);
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [1:0]  grant_q;
  logic        lat_wen;
  logic [3:0]  lat_be;
  logic [29:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        any_req, tie, pick_m1;

`ifdef ARB_CPU_PRIO_EN
  localparam int unsigned STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_cnt;
`else
  logic last_grant;  // 1 = m1 owned the previous transfer
`endif

  assign any_req = m0_req | m1_req;
  assign tie     = m0_req & m1_req;

  always_comb begin
    pick_m1 = m1_req & ~m0_req;
    if (tie) begin
`ifdef ARB_CPU_PRIO_EN
      pick_m1 = (starve_cnt == STARVE_W'(STARVE_MAX));
`else
      pick_m1 = ~last_grant;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (any_req) state_nxt = S_ACCESS;
      S_ACCESS: if (wait_cnt == '0) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= '0;
      grant_q    <= '0;
      lat_wen    <= 1'b0;
      lat_be     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
`ifdef ARB_CPU_PRIO_EN
      starve_cnt <= '0;
`else
      last_grant <= 1'b1;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (any_req) begin
          wait_cnt  <= 4'(MEM_LAT - 1);
          grant_q   <= pick_m1 ? 2'b10 : 2'b01;
          lat_wen   <= pick_m1 ? m1_wen   : m0_wen;
          lat_be    <= pick_m1 ? m1_be    : m0_be;
          lat_addr  <= pick_m1 ? m1_addr  : m0_addr;
          lat_wdata <= pick_m1 ? m1_wdata : m0_wdata;
`ifdef ARB_CPU_PRIO_EN
          if (pick_m1)
            starve_cnt <= '0;
          else if (tie && starve_cnt != STARVE_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
`endif
        end
        S_ACCESS: begin
          if (wait_cnt == '0) begin
            if (!lat_wen && grant_q[0]) m0_rdata <= mem_rdata;
            if (!lat_wen && grant_q[1]) m1_rdata <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RESP: begin
          grant_q <= '0;
`ifndef ARB_CPU_PRIO_EN
          last_grant <= grant_q[1];
`endif
        end
        default: grant_q <= '0;
      endcase
    end
  end

  always_comb begin
    mem_be  = '0;
    mem_wen = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    busy    = (state != S_IDLE);
    if (state == S_ACCESS) begin
      mem_be  = lat_be;
      mem_wen = lat_wen && (wait_cnt == '0);
    end
    if (state == S_RESP) begin
      m0_ack = grant_q[0];
      m1_ack = grant_q[1];
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with MEM_LAT=2, STARVE_MAX=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [3:0]  m0_be, m1_be;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_wen;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  grant;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    m0_req = 0; m0_wen = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wen = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({grant, busy, mem_wen, mem_be, m0_ack, m1_ack} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got grant=%b busy=%b wen=%b be=%b ack=%b%b required all 0",
               grant, busy, mem_wen, mem_be, m1_ack, m0_ack);
    end
    vectors++;
    if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 126'b0) begin
      miscompares++;
      $display("FAIL reset_data got addr=%h wdata=%h r0=%h r1=%h required 0",
               mem_addr, mem_wdata, m0_rdata, m1_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  // Cycle 0 is the current falling edge; request presented here.
  task automatic test_m0_read;
    m0_req = 1; m0_wen = 0; m0_be = 4'hF; m0_addr = 30'h40;
    mem_rdata = 32'hDEADBEEF;
    for (int c = 1; c <= 2; c++) begin
      tick();
      vectors++;
      if (mem_addr !== 30'h40 || mem_be !== 4'hF || grant !== 2'b01 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL read_access_c%0d got addr=%h be=%h grant=%b busy=%b required 40 f 01 1",
                 c, mem_addr, mem_be, grant, busy);
      end
      vectors++;
      if (mem_wen !== 1'b0 || m0_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL read_noack_c%0d got wen=%b ack=%b required 0 0", c, mem_wen, m0_ack);
      end
    end
    tick();
    vectors++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_ack !== 1'b0 || mem_be !== 4'h0) begin
      miscompares++;
      $display("FAIL read_resp got ack0=%b rdata=%h ack1=%b be=%h required 1 deadbeef 0 0",
               m0_ack, m0_rdata, m1_ack, mem_be);
    end
    m0_req = 0;
    mem_rdata = 32'h0;
    tick();
    vectors++;
    if (busy !== 1'b0 || grant !== 2'b00 || m0_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL read_idle got busy=%b grant=%b ack=%b required 0 00 0", busy, grant, m0_ack);
    end
  endtask

  task automatic test_m1_write;
    m1_req = 1; m1_wen = 1; m1_be = 4'b0011; m1_addr = 30'h123; m1_wdata = 32'h1234_5678;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    vectors++;
    if (mem_wen !== 1'b0 || mem_be !== 4'b0011 || grant !== 2'b10 || mem_addr !== 30'h123) begin
      miscompares++;
      $display("FAIL write_c1 got wen=%b be=%b grant=%b addr=%h required 0 0011 10 123",
               mem_wen, mem_be, grant, mem_addr);
    end
    tick();
    vectors++;
    if (mem_wen !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_c2 got wen=%b be=%b wdata=%h required 1 0011 12345678",
               mem_wen, mem_be, mem_wdata);
    end
    tick();
    vectors++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || mem_wen !== 1'b0 || m1_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL write_resp got ack1=%b ack0=%b wen=%b rdata1=%h required 1 0 0 0",
               m1_ack, m0_ack, mem_wen, m1_rdata);
    end
    m1_req = 0; m1_wen = 0;
    mem_rdata = 32'h0;
    tick();
  endtask

  // Both masters held from reset; order bit k = 1 means grant k goes to m1.
  task automatic test_tie;
    logic [7:0] order;
    int n;
`ifdef ARB_CPU_PRIO_EN
    order = 8'b1000_1000; n = 8;
`else
    order = 8'b0000_1010; n = 4;
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    m0_req = 1; m0_wen = 0; m0_be = 4'hF; m0_addr = 30'h100;
    m1_req = 1; m1_wen = 0; m1_be = 4'hF; m1_addr = 30'h200;
    mem_rdata = 32'hA5A5_0001;
    for (int k = 0; k < n; k++) begin
      tick();
      vectors++;
      if (grant !== (order[k] ? 2'b10 : 2'b01) || mem_addr !== (order[k] ? 30'h200 : 30'h100)) begin
        miscompares++;
        $display("FAIL tie_grant_%0d got grant=%b addr=%h required owner m%0d", k, grant, mem_addr, order[k]);
      end
      tick(); tick();
      vectors++;
      if (m0_ack !== ~order[k] || m1_ack !== order[k]) begin
        miscompares++;
        $display("FAIL tie_ack_%0d got ack0=%b ack1=%b required m%0d at cycle %0d",
                 k, m0_ack, m1_ack, order[k], 4 * k + 3);
      end
      if (k == n - 1) begin
        m0_req = 0; m1_req = 0;
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || grant !== 2'b00) begin
        miscompares++;
        $display("FAIL tie_idle_%0d got busy=%b grant=%b required 0 00", k, busy, grant);
      end
    end
    mem_rdata = 32'h0;
  endtask

  task automatic test_reset_mid;
    logic seen_wen;
    logic seen_ack;
    seen_wen = 0; seen_ack = 0;
    m0_req = 1; m0_wen = 1; m0_be = 4'hF; m0_addr = 30'h55; m0_wdata = 32'hBAD0_BAD0;
    tick();
    seen_wen = seen_wen | mem_wen;
    rst = 1'b1;
    m0_req = 0;
    #1;
    vectors++;
    if (grant !== 2'b00 || busy !== 1'b0 || mem_wen !== 1'b0 || mem_be !== 4'h0) begin
      miscompares++;
      $display("FAIL rstmid_async got grant=%b busy=%b wen=%b be=%h required 00 0 0 0",
               grant, busy, mem_wen, mem_be);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen_wen = seen_wen | mem_wen;
      seen_ack = seen_ack | m0_ack | m1_ack;
    end
    vectors++;
    if (seen_wen !== 1'b0 || seen_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_quiet got wen_seen=%b ack_seen=%b required 0 0", seen_wen, seen_ack);
    end
    m0_req = 1; m0_wen = 1; m0_be = 4'b1100; m0_addr = 30'h56; m0_wdata = 32'h0BAD_F00D;
    tick(); tick();
    vectors++;
    if (mem_wen !== 1'b1 || mem_addr !== 30'h56 || mem_wdata !== 32'h0BAD_F00D || mem_be !== 4'b1100) begin
      miscompares++;
      $display("FAIL rstmid_fresh_wr got wen=%b addr=%h wdata=%h be=%b required 1 56 0badf00d 1100",
               mem_wen, mem_addr, mem_wdata, mem_be);
    end
    tick();
    vectors++;
    if (m0_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_fresh_ack got %b required 1", m0_ack);
    end
    m0_req = 0; m0_wen = 0;
    tick();
  endtask

  // m0 drops req and scrambles its fields once granted; latched copy must be used.
  task automatic test_drop_req;
    m0_req = 1; m0_wen = 0; m0_be = 4'b0101; m0_addr = 30'h3AB;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    m0_req = 0; m0_addr = 30'h111; m0_be = 4'hF; m0_wen = 1;
    tick();
    vectors++;
    if (busy !== 1'b1 || mem_addr !== 30'h3AB || mem_be !== 4'b0101 || mem_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_c2 got busy=%b addr=%h be=%b wen=%b required 1 3ab 0101 0",
               busy, mem_addr, mem_be, mem_wen);
    end
    tick();
    vectors++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL drop_resp got ack=%b rdata=%h required 1 cafef00d", m0_ack, m0_rdata);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || grant !== 2'b00 || m0_ack !== 1'b0 || m0_rdata !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL drop_idle got busy=%b grant=%b ack=%b rdata=%h required 0 00 0 cafef00d",
               busy, grant, m0_ack, m0_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write();
    test_tie();
    test_reset_mid();
    test_drop_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout bench did not finish by 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
